// File: rtl/spi_slave_core.sv
// SPI slave endpoint oversampled entirely in the PCLK domain: all four CPOL/CPHA
// modes, MSB/LSB-first frames, single-entry TX buffer and RX holding register.
module spi_slave_core #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  en,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsbfe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  output logic                  rx_overrun,
  output logic                  busy,
  input  logic                  sclk,
  input  logic                  ss,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;

  logic sclk_s;
  logic ss_s;
  logic mosi_s;
  logic rise_s;
  logic fall_s;
  logic lead_s;
  logic trail_s;
  logic sample_s;
  logic shift_s;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  first_shift_q, first_shift_d;
  logic [DATA_WIDTH-1:0] tx_shreg_q, tx_shreg_d;
  logic [DATA_WIDTH-1:0] rx_shreg_q, rx_shreg_d;
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic                  tx_ready_q, tx_ready_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_overrun_q, rx_overrun_d;

  logic                  start_s;
  logic                  abort_s;
  logic                  frame_done_s;
  logic                  xfer_s;
  logic                  load_ok_s;
  logic [DATA_WIDTH-1:0] fill_s;

  // ss synchroniser resets to the inactive (high) level so a fresh reset never
  // looks like a select and consumes the TX buffer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sclk_sync_q <= {SYNC_STAGES{1'b0}};
      ss_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= {SYNC_STAGES{1'b0}};
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign rise_s   = sclk_s & ~sclk_prev_q;
  assign fall_s   = ~sclk_s & sclk_prev_q;
  assign lead_s   = cpol ? fall_s : rise_s;
  assign trail_s  = cpol ? rise_s : fall_s;
  assign sample_s = cpha ? trail_s : lead_s;
  assign shift_s  = cpha ? lead_s : trail_s;

  assign start_s      = (state_q == ST_IDLE) & en & ~ss_s;
  assign abort_s      = (state_q == ST_ACTIVE) & (ss_s | ~en);
  assign frame_done_s = (state_q == ST_ACTIVE) & (bit_cnt_q == CNT_LAST);
  assign xfer_s       = start_s | (frame_done_s & ~abort_s);
  assign load_ok_s    = tx_load & tx_ready_q;
  assign fill_s       = tx_ready_q ? {DATA_WIDTH{1'b1}} : tx_buf_q;

  // Frame FSM, shift registers and TX/RX holding logic.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    first_shift_d = first_shift_q;
    tx_shreg_d    = tx_shreg_q;
    rx_shreg_d    = rx_shreg_q;
    tx_buf_d      = tx_buf_q;
    tx_ready_d    = tx_ready_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    rx_overrun_d  = rx_overrun_q;

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d     = {CNT_W{1'b0}};
        first_shift_d = 1'b1;
        if (start_s) begin
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (abort_s) begin
          state_d = ST_IDLE;
        end else if (frame_done_s) begin
          bit_cnt_d     = {CNT_W{1'b0}};
          first_shift_d = 1'b1;
        end else if (sample_s) begin
          if (lsbfe) begin
            rx_shreg_d = {mosi_s, rx_shreg_q[DATA_WIDTH-1:1]};
          end else begin
            rx_shreg_d = {rx_shreg_q[DATA_WIDTH-2:0], mosi_s};
          end
          bit_cnt_d = bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (shift_s) begin
          // The first shift edge after a (re)load must not consume the first bit:
          // with cpha=1 it is the opening leading edge, with cpha=0 it is the
          // trailing edge of the previous frame's last bit.
          first_shift_d = 1'b0;
          if (first_shift_q && (cpha || (bit_cnt_q == {CNT_W{1'b0}}))) begin
            tx_shreg_d = tx_shreg_q;
          end else if (lsbfe) begin
            tx_shreg_d = {1'b0, tx_shreg_q[DATA_WIDTH-1:1]};
          end else begin
            tx_shreg_d = {tx_shreg_q[DATA_WIDTH-2:0], 1'b0};
          end
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (xfer_s) begin
      tx_shreg_d = fill_s;
    end else begin
      tx_shreg_d = tx_shreg_d;
    end

    if (load_ok_s) begin
      tx_buf_d   = tx_data;
      tx_ready_d = 1'b0;
    end else if (xfer_s) begin
      tx_ready_d = 1'b1;
    end else begin
      tx_ready_d = tx_ready_q;
    end

    // A coincident ack wins against overrun: the consumer has taken the old byte.
    if (frame_done_s) begin
      rx_data_d    = rx_shreg_q;
      rx_valid_d   = 1'b1;
      rx_overrun_d = rx_ack ? 1'b0 : (rx_overrun_q | rx_valid_q);
    end else if (rx_ack) begin
      rx_valid_d   = 1'b0;
      rx_overrun_d = 1'b0;
    end else begin
      rx_valid_d   = rx_valid_q;
    end
  end

  // Core state registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= {CNT_W{1'b0}};
      first_shift_q <= 1'b1;
      tx_shreg_q    <= {DATA_WIDTH{1'b0}};
      rx_shreg_q    <= {DATA_WIDTH{1'b0}};
      tx_buf_q      <= {DATA_WIDTH{1'b0}};
      tx_ready_q    <= 1'b1;
      rx_data_q     <= {DATA_WIDTH{1'b0}};
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      first_shift_q <= first_shift_d;
      tx_shreg_q    <= tx_shreg_d;
      rx_shreg_q    <= rx_shreg_d;
      tx_buf_q      <= tx_buf_d;
      tx_ready_q    <= tx_ready_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
    end
  end

  // miso is taken straight from the shift register while a frame is active.
  always_comb begin
    miso = 1'b0;
    if (state_q == ST_ACTIVE) begin
      miso = lsbfe ? tx_shreg_q[0] : tx_shreg_q[DATA_WIDTH-1];
    end else begin
      miso = 1'b0;
    end
  end

  assign busy       = (state_q == ST_ACTIVE);
  assign miso_oe    = busy;
  assign tx_ready   = tx_ready_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_overrun_q;

endmodule
